// File: rtl/rtc_seq_pkg.sv
// Shared constants for the RTC sequencer: field register addresses, BCD limits,
// FSM state type and default timing parameters.
package rtc_seq_pkg;

  localparam int         TXN_LEN_DEF     = 256;
  localparam int         GAP_LEN_DEF     = 4;
  localparam logic [7:0] CAPTURE_CYC_DEF = 8'hC0;
  localparam int         NUM_FIELDS      = 6;

  localparam logic [7:0] ADDR_SEC   = 8'h21;
  localparam logic [7:0] ADDR_MIN   = 8'h22;
  localparam logic [7:0] ADDR_HOUR  = 8'h23;
  localparam logic [7:0] ADDR_DATE  = 8'h24;
  localparam logic [7:0] ADDR_MONTH = 8'h25;
  localparam logic [7:0] ADDR_YEAR  = 8'h26;

  localparam logic [7:0] LIM_SEC_LO   = 8'h00, LIM_SEC_HI   = 8'h59;
  localparam logic [7:0] LIM_MIN_LO   = 8'h00, LIM_MIN_HI   = 8'h59;
  localparam logic [7:0] LIM_HOUR_LO  = 8'h00, LIM_HOUR_HI  = 8'h23;
  localparam logic [7:0] LIM_DATE_LO  = 8'h01, LIM_DATE_HI  = 8'h31;
  localparam logic [7:0] LIM_MONTH_LO = 8'h01, LIM_MONTH_HI = 8'h12;
  localparam logic [7:0] LIM_YEAR_LO  = 8'h00, LIM_YEAR_HI  = 8'h99;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_TXN,
    ST_GAP,
    ST_WRITE_TXN
  } state_e;

  function automatic logic [7:0] field_addr(input logic [2:0] f);
    case (f)
      3'd0:    return ADDR_SEC;
      3'd1:    return ADDR_MIN;
      3'd2:    return ADDR_HOUR;
      3'd3:    return ADDR_DATE;
      3'd4:    return ADDR_MONTH;
      default: return ADDR_YEAR;
    endcase
  endfunction

  function automatic logic [7:0] field_lo(input logic [2:0] f);
    case (f)
      3'd0:    return LIM_SEC_LO;
      3'd1:    return LIM_MIN_LO;
      3'd2:    return LIM_HOUR_LO;
      3'd3:    return LIM_DATE_LO;
      3'd4:    return LIM_MONTH_LO;
      default: return LIM_YEAR_LO;
    endcase
  endfunction

  function automatic logic [7:0] field_hi(input logic [2:0] f);
    case (f)
      3'd0:    return LIM_SEC_HI;
      3'd1:    return LIM_MIN_HI;
      3'd2:    return LIM_HOUR_HI;
      3'd3:    return LIM_DATE_HI;
      3'd4:    return LIM_MONTH_HI;
      default: return LIM_YEAR_HI;
    endcase
  endfunction

endpackage

// File: rtl/bcd_step.sv
// Combinational wrapping BCD increment/decrement within [min_val, max_val].
module bcd_step (
  input  logic [7:0] value,
  input  logic [7:0] min_val,
  input  logic [7:0] max_val,
  input  logic       dir_inc,
  output logic [7:0] next_val
);

  // Out-of-range values (e.g. a cleared date of 00) snap to the wrap target.
  always_comb begin
    next_val = value;
    if (dir_inc) begin
      if ((value >= max_val) || (value < min_val)) next_val = min_val;
      else if (value[3:0] >= 4'd9)                 next_val = {value[7:4] + 4'd1, 4'd0};
      else                                         next_val = {value[7:4], value[3:0] + 4'd1};
    end else begin
      if ((value <= min_val) || (value > max_val)) next_val = max_val;
      else if (value[3:0] == 4'd0)                 next_val = {value[7:4] - 4'd1, 4'd9};
      else                                         next_val = {value[7:4], value[3:0] - 4'd1};
    end
  end

endmodule

// File: rtl/rtc_sequencer.sv
// RTC bus sequencer: sweeps reads of the six time fields and slots in user edits.
// Optional macro RTC_SEQ_BCD_CHECK_EN sanitises invalid captured BCD and adds bcd_err.
//   state        | meaning
//   ST_IDLE      | one cycle after reset before the first read
//   ST_READ_TXN  | reading the field selected by the sweep index
//   ST_GAP       | idle spacing between transactions
//   ST_WRITE_TXN | writing the stepped value of the pending edit field
module rtc_sequencer
  import rtc_seq_pkg::*;
#(
  parameter int         TXN_LEN     = TXN_LEN_DEF,
  parameter int         GAP_LEN     = GAP_LEN_DEF,
  parameter logic [7:0] CAPTURE_CYC = CAPTURE_CYC_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       edit_inc,
  input  logic       edit_dec,
  input  logic [2:0] field_sel,
  input  logic [7:0] data_vga,
  output logic [7:0] address,
  output logic [7:0] data_write,
  output logic       indicador_maquina,
  output logic       txn_active,
  output logic [7:0] seg,
  output logic [7:0] min,
  output logic [7:0] hora,
  output logic [7:0] dia,
  output logic [7:0] mes,
  output logic [7:0] anio
`ifdef RTC_SEQ_BCD_CHECK_EN
  ,
  output logic       bcd_err
`endif
);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gap_q, gap_d;
  logic [2:0] sweep_q, sweep_d;
  logic       pend_q, pend_d;
  logic [2:0] pend_field_q, pend_field_d;
  logic       pend_inc_q, pend_inc_d;
  logic [7:0] address_q, address_d;
  logic [7:0] data_write_q, data_write_d;
  logic       ind_q, ind_d;
  logic       active_q, active_d;
  logic [7:0] shadow_q [NUM_FIELDS];
  logic [7:0] shadow_d [NUM_FIELDS];
  logic [7:0] edit_val, step_val, cap_val;
  logic       edit_ok, txn_last;
`ifdef RTC_SEQ_BCD_CHECK_EN
  logic       bcd_err_q, bcd_err_d, cap_bad;
`endif

  bcd_step u_bcd_step (
    .value   (edit_val),
    .min_val (field_lo(pend_field_q)),
    .max_val (field_hi(pend_field_q)),
    .dir_inc (pend_inc_q),
    .next_val(step_val)
  );

  always_comb begin
    edit_val = 8'h00;
    for (int i = 0; i < NUM_FIELDS; i++)
      if (pend_field_q == 3'(i)) edit_val = shadow_q[i];
  end

  assign edit_ok  = (edit_inc ^ edit_dec) && (field_sel < 3'(NUM_FIELDS));
  assign txn_last = (cnt_q == 8'(TXN_LEN - 1));

`ifdef RTC_SEQ_BCD_CHECK_EN
  assign cap_bad = (data_vga[7:4] > 4'd9) || (data_vga[3:0] > 4'd9);
  assign cap_val = cap_bad ? field_lo(sweep_q) : data_vga;
`else
  assign cap_val = data_vga;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q + 8'd1;
    gap_d        = gap_q;
    sweep_d      = sweep_q;
    pend_d       = pend_q;
    pend_field_d = pend_field_q;
    pend_inc_d   = pend_inc_q;
    address_d    = address_q;
    data_write_d = data_write_q;
    ind_d        = ind_q;
    active_d     = active_q;
    shadow_d     = shadow_q;
`ifdef RTC_SEQ_BCD_CHECK_EN
    bcd_err_d    = bcd_err_q;
`endif

    if (!pend_q && edit_ok) begin
      pend_d       = 1'b1;
      pend_field_d = field_sel;
      pend_inc_d   = edit_inc;
    end

    case (state_q)
      ST_IDLE: begin
        state_d   = ST_READ_TXN;
        cnt_d     = 8'd0;
        address_d = field_addr(sweep_q);
        ind_d     = 1'b1;
        active_d  = 1'b1;
      end
      ST_READ_TXN: begin
        if (cnt_q == CAPTURE_CYC) begin
          for (int i = 0; i < NUM_FIELDS; i++)
            if (sweep_q == 3'(i)) shadow_d[i] = cap_val;
`ifdef RTC_SEQ_BCD_CHECK_EN
          if (cap_bad) bcd_err_d = 1'b1;
`endif
        end
        if (txn_last) begin
          state_d   = ST_GAP;
          gap_d     = 8'(GAP_LEN - 1);
          address_d = 8'h00;
          ind_d     = 1'b1;
          active_d  = 1'b0;
          sweep_d   = (sweep_q == 3'(NUM_FIELDS - 1)) ? 3'd0 : sweep_q + 3'd1;
        end
      end
      ST_WRITE_TXN: begin
        if (txn_last) begin
          for (int i = 0; i < NUM_FIELDS; i++)
            if (pend_field_q == 3'(i)) shadow_d[i] = data_write_q;
          pend_d    = 1'b0;
          sweep_d   = 3'd0;
          state_d   = ST_GAP;
          gap_d     = 8'(GAP_LEN - 1);
          address_d = 8'h00;
          ind_d     = 1'b1;
          active_d  = 1'b0;
        end
      end
      ST_GAP: begin
        gap_d = gap_q - 8'd1;
        if (gap_q == 8'd0) begin
          cnt_d    = 8'd0;
          active_d = 1'b1;
          if (pend_q) begin
            state_d      = ST_WRITE_TXN;
            address_d    = field_addr(pend_field_q);
            data_write_d = step_val;
            ind_d        = 1'b0;
          end else begin
            state_d   = ST_READ_TXN;
            address_d = field_addr(sweep_q);
            ind_d     = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 8'd0;
      gap_q        <= 8'd0;
      sweep_q      <= 3'd0;
      pend_q       <= 1'b0;
      pend_field_q <= 3'd0;
      pend_inc_q   <= 1'b0;
      address_q    <= 8'h00;
      data_write_q <= 8'h00;
      ind_q        <= 1'b1;
      active_q     <= 1'b0;
      shadow_q     <= '{default: 8'h00};
`ifdef RTC_SEQ_BCD_CHECK_EN
      bcd_err_q    <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      gap_q        <= gap_d;
      sweep_q      <= sweep_d;
      pend_q       <= pend_d;
      pend_field_q <= pend_field_d;
      pend_inc_q   <= pend_inc_d;
      address_q    <= address_d;
      data_write_q <= data_write_d;
      ind_q        <= ind_d;
      active_q     <= active_d;
      shadow_q     <= shadow_d;
`ifdef RTC_SEQ_BCD_CHECK_EN
      bcd_err_q    <= bcd_err_d;
`endif
    end
  end

  assign address           = address_q;
  assign data_write        = data_write_q;
  assign indicador_maquina = ind_q;
  assign txn_active        = active_q;
  assign seg  = shadow_q[0];
  assign min  = shadow_q[1];
  assign hora = shadow_q[2];
  assign dia  = shadow_q[3];
  assign mes  = shadow_q[4];
  assign anio = shadow_q[5];
`ifdef RTC_SEQ_BCD_CHECK_EN
  assign bcd_err = bcd_err_q;
`endif

endmodule

// File: tb/tb_rtc_sequencer.sv
// Transaction-level bench for rtc_sequencer: random read data and edits checked
// against a decimal model of the shadow fields and the pending edit.
module tb_rtc_sequencer;

  localparam int TXN_LEN = 256;
  localparam int GAP_LEN = 4;
  localparam int CAP     = 'hC0;

  logic       clk = 1'b0, reset = 1'b1, edit_inc = 1'b0, edit_dec = 1'b0;
  logic [2:0] field_sel = 3'd0;
  logic [7:0] data_vga = 8'h00;
  logic [7:0] address, data_write, seg, min, hora, dia, mes, anio;
  logic       indicador_maquina, txn_active;
`ifdef RTC_SEQ_BCD_CHECK_EN
  logic       bcd_err;
`endif

  rtc_sequencer #(.TXN_LEN(TXN_LEN), .GAP_LEN(GAP_LEN), .CAPTURE_CYC(8'hC0)) dut (
    .clk(clk), .reset(reset), .edit_inc(edit_inc), .edit_dec(edit_dec),
    .field_sel(field_sel), .data_vga(data_vga), .address(address),
    .data_write(data_write), .indicador_maquina(indicador_maquina),
    .txn_active(txn_active), .seg(seg), .min(min), .hora(hora), .dia(dia),
    .mes(mes), .anio(anio)
`ifdef RTC_SEQ_BCD_CHECK_EN
    , .bcd_err(bcd_err)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  // reference model state
  int sh [6];
  bit pend, pinc, err_m;
  int pf, sweep;

  typedef struct { int cyc; bit inc; bit dec; int f; } edit_t;
  edit_t edq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int fmin(input int f);
    return (f == 3 || f == 4) ? 1 : 0;
  endfunction

  function automatic int fmax(input int f);
    case (f)
      0, 1:    return 59;
      2:       return 23;
      3:       return 31;
      4:       return 12;
      default: return 99;
    endcase
  endfunction

  function automatic int to_bcd(input int n);
    return ((n / 10) << 4) | (n % 10);
  endfunction

  function automatic int from_bcd(input int b);
    return ((b >> 4) & 15) * 10 + (b & 15);
  endfunction

  function automatic int bcd_next(input int b, input bit inc, input int f);
    int v, n;
    v = from_bcd(b);
    if (inc) n = (v >= fmax(f) || v < fmin(f)) ? fmin(f) : v + 1;
    else     n = (v <= fmin(f) || v > fmax(f)) ? fmax(f) : v - 1;
    return to_bcd(n);
  endfunction

  function automatic int capture_model(input int b, input int f);
`ifdef RTC_SEQ_BCD_CHECK_EN
    if (((b >> 4) & 15) > 9 || (b & 15) > 9) begin
      err_m = 1'b1;
      return to_bcd(fmin(f));
    end
`endif
    return b;
  endfunction

  function automatic logic [7:0] field_val(input int f);
    case (f)
      0:       return seg;
      1:       return min;
      2:       return hora;
      3:       return dia;
      4:       return mes;
      default: return anio;
    endcase
  endfunction

  task automatic model_reset();
    foreach (sh[i]) sh[i] = 0;
    pend = 0; pinc = 0; pf = 0; sweep = 0; err_m = 0;
  endtask

  task automatic check_reset_vals();
    chk("rst_address", address, 8'h00);
    chk("rst_data_write", data_write, 8'h00);
    chk("rst_ind", indicador_maquina, 1'b1);
    chk("rst_active", txn_active, 1'b0);
    for (int i = 0; i < 6; i++) chk("rst_field", field_val(i), 8'h00);
`ifdef RTC_SEQ_BCD_CHECK_EN
    chk("rst_bcd_err", bcd_err, 1'b0);
`endif
  endtask

  // Called at a negedge; follows one gap (bounded) and one transaction.
  task automatic run_txn(input int exp_gap, input int data, input int abort_at);
    int gap, gap_bad, hold_bad, f;
    bit wr;
    logic [7:0] ea, ed, cap, cur_dw;
    logic ei;
    gap = 0; gap_bad = 0; hold_bad = 0;
    while (txn_active !== 1'b1 && gap < GAP_LEN + 4) begin
      if (address !== 8'h00 || indicador_maquina !== 1'b1) gap_bad++;
      gap++;
      @(negedge clk);
    end
    chk("gap_len", gap, exp_gap);
    chk("gap_outputs", gap_bad, 0);
    wr  = pend;
    f   = wr ? pf : sweep;
    ea  = 8'(8'h21 + f);
    ei  = !wr;
    ed  = wr ? 8'(bcd_next(sh[f], pinc, f)) : 8'h00;
    cap = (data >= 0) ? 8'(data) : 8'(to_bcd($urandom_range(fmax(f), fmin(f))));
    if (!wr) data_vga = cap;
    chk("txn_addr", address, ea);
    chk("txn_ind", indicador_maquina, ei);
    if (wr) chk("write_data", data_write, ed);
    cur_dw = data_write;
    for (int c = 0; c < TXN_LEN; c++) begin
      if (c == abort_at) begin
        reset = 1'b1; edit_inc = 1'b0; edit_dec = 1'b0;
        @(negedge clk);
        check_reset_vals();
        model_reset();
        edq.delete();
        reset = 1'b0;
        @(negedge clk);
        return;
      end
      if (address !== ea || indicador_maquina !== ei || data_write !== cur_dw || txn_active !== 1'b1)
        hold_bad++;
      if (!wr && c == CAP) chk("pre_capture", field_val(f), sh[f]);
      if (!wr && c == CAP + 1) begin
        sh[f] = capture_model(cap, f);
        chk("capture", field_val(f), sh[f]);
      end
      edit_inc = 1'b0; edit_dec = 1'b0;
      foreach (edq[k]) if (edq[k].cyc == c) begin
        edit_inc = edq[k].inc; edit_dec = edq[k].dec; field_sel = 3'(edq[k].f);
        if (!pend && (edq[k].inc ^ edq[k].dec)) begin
          pend = 1; pf = edq[k].f; pinc = edq[k].inc;
        end
      end
      @(negedge clk);
    end
    edit_inc = 1'b0; edit_dec = 1'b0;
    edq.delete();
    chk("txn_hold", hold_bad, 0);
    if (wr) begin
      sh[f] = ed; pend = 0; sweep = 0;
      chk("write_shadow", field_val(f), ed);
    end else begin
      sweep = (sweep + 1) % 6;
    end
`ifdef RTC_SEQ_BCD_CHECK_EN
    chk("bcd_err", bcd_err, err_m);
`endif
  endtask

  task automatic add_edit(input int cyc, input bit inc, input bit dec, input int f);
    edit_t e;
    e.cyc = cyc; e.inc = inc; e.dec = dec; e.f = f;
    edq.push_back(e);
  endtask

  initial begin
    model_reset();
    data_vga = 8'h45;
    repeat (3) @(negedge clk);
    check_reset_vals();
    reset = 1'b0;
    @(negedge clk);

    run_txn(0, 'h45, -1);
    chk("seg_first_read", seg, 8'h45);
    for (int i = 0; i < 5; i++) run_txn(GAP_LEN, -1, -1);
    run_txn(GAP_LEN, 'h59, -1);

    add_edit(40, 1'b1, 1'b0, 0);
    run_txn(GAP_LEN, -1, -1);
    run_txn(GAP_LEN, -1, -1);
    chk("seg_inc_wrap", seg, 8'h00);

    for (int i = 0; i < 4; i++) run_txn(GAP_LEN, -1, -1);
    add_edit(10, 1'b1, 1'b1, 4);
    add_edit(20, 1'b0, 1'b1, 4);
    add_edit(30, 1'b1, 1'b0, 0);
    run_txn(GAP_LEN, 'h01, -1);
    run_txn(GAP_LEN, -1, -1);
    chk("mes_dec_wrap", mes, 8'h12);
    run_txn(GAP_LEN, -1, -1);
    chk("single_write_then_read", address, 8'h00);

    for (int t = 0; t < 8; t++) begin
      int r;
      if ($urandom_range(1, 0) == 1) begin
        r = $urandom_range(3, 0);
        add_edit($urandom_range(120, 5), r != 2, r != 1, $urandom_range(5, 0));
      end
      if ($urandom_range(3, 0) == 0)
        add_edit($urandom_range(250, 130), 1'($urandom_range(1, 0)), 1'b0, $urandom_range(5, 0));
      run_txn(GAP_LEN, -1, -1);
    end

    add_edit(50, 1'b0, 1'b1, 2);
    run_txn(GAP_LEN, -1, 100);
    run_txn(0, -1, -1);

`ifdef RTC_SEQ_BCD_CHECK_EN
    run_txn(GAP_LEN, -1, -1);
    run_txn(GAP_LEN, 'h3A, -1);
    chk("hora_sanitised", hora, 8'h00);
    chk("bcd_err_set", bcd_err, 1'b1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtc_sequencer.md
RTC_SEQUENCER -- requirements
Module: rtc_sequencer

Interface
REQ-001 Parameter TXN_LEN, default 256: clk cycles per RTC bus transaction.
REQ-002 Parameter GAP_LEN, default 4: idle cycles between transactions.
REQ-003 Parameter CAPTURE_CYC, default 8'hC0: transaction cycle at which read data is sampled.
REQ-004 clk  in  1  system clock, 100 MHz.
REQ-005 reset  in  1  synchronous, active-high reset.
REQ-006 edit_inc / edit_dec  in  1 each  single-cycle user edit pulses.
REQ-007 field_sel  in  3  edit target: 0 sec, 1 min, 2 hour, 3 date, 4 month, 5 year.
REQ-008 data_vga  in  8  read byte returned by the protocol stage.
REQ-009 address  out  8  RTC register address for the current transaction.
REQ-010 data_write  out  8  BCD byte for write transactions.
REQ-011 indicador_maquina  out  1  1 = read transaction, 0 = write transaction.
REQ-012 txn_active  out  1  high during every transaction cycle.
REQ-013 seg, min, hora, dia, mes, anio  out  8 each  registered BCD shadow of the RTC fields, consumed by VGA.
REQ-014 bcd_err  out  1  sticky invalid-BCD flag, present only under the macro.

Function
REQ-015 Field addresses: sec 8'h21, min 8'h22, hour 8'h23, date 8'h24, month 8'h25, year 8'h26.
REQ-016 FSM states: IDLE, READ_TXN, GAP, WRITE_TXN.
REQ-017 Transitions: IDLE->READ_TXN on the first cycle after reset deasserts; READ_TXN/WRITE_TXN->GAP after TXN_LEN cycles; GAP->WRITE_TXN if an edit is pending, else GAP->READ_TXN after GAP_LEN cycles.
REQ-018 An internal 8-bit transaction counter starts at 0 on transaction entry and increments every cycle.
REQ-019 address, data_write and indicador_maquina are constant for the whole transaction.
REQ-020 In GAP: address = 8'h00, indicador_maquina = 1, txn_active = 0.
REQ-021 Read sweep order: 8'h21..8'h26, then wraps to 8'h21.
REQ-022 In READ_TXN, data_vga is sampled at counter == CAPTURE_CYC into the addressed shadow field; the new value is visible on the next cycle.
REQ-023 An edit pulse latches a one-deep pending request (field, direction) in any state.
REQ-024 A further pulse while a request is pending is dropped.
REQ-025 edit_inc and edit_dec asserted in the same cycle are ignored.
REQ-026 A pending edit is serviced at the next GAP end and never aborts a running transaction.
REQ-027 WRITE_TXN drives: address = field address, indicador_maquina = 0, data_write = BCD step of the current shadow value.
REQ-028 BCD step limits, wrapping: sec/min 00-59, hour 00-23, date 01-31, month 01-12, year 00-99; inc at max -> min, dec at min -> max.
REQ-029 At the end of a WRITE_TXN: the shadow field takes data_write in the same cycle, the pending request clears, and the read sweep restarts at 8'h21.

Reset
REQ-030 Reset overrides all activity, including mid-transaction, and aborts the transaction.
REQ-031 Reset values: state IDLE, counter 0, address 8'h00, data_write 8'h00, indicador_maquina 1, txn_active 0.
REQ-032 Reset also clears the pending request, bcd_err and all shadow fields to 8'h00.

Configuration
REQ-033 Macro RTC_SEQ_BCD_CHECK_EN defined: a captured byte with either nibble > 9 is stored as the field minimum and sets bcd_err until reset.
REQ-034 Macro RTC_SEQ_BCD_CHECK_EN undefined: captured bytes are stored raw, and bcd_err is absent.

Structure
REQ-035 Package rtc_seq_pkg holds: field address constants, per-field min/max BCD limits, the FSM state enum, and default TXN_LEN/GAP_LEN/CAPTURE_CYC.
REQ-036 Sub-module bcd_step is combinational (value, min, max, dir -> next value) and is instantiated once.

Verification
REQ-037 Reset release, data_vga held 8'h45 -> first READ_TXN on address 8'h21, indicador_maquina 1; seg = 8'h45 at transaction cycle CAPTURE_CYC+1.
REQ-038 Free run, 6*(TXN_LEN+GAP_LEN) cycles -> addresses 8'h21..8'h26 in order, then 8'h21 again; 4 gap cycles at 8'h00 between transactions.
REQ-039 seg = 8'h59, edit_inc with field_sel 0 -> WRITE_TXN, address 8'h21, data_write 8'h00, indicador_maquina 0; seg = 8'h00; next read at 8'h21.
REQ-040 mes = 8'h01, edit_dec with field_sel 4 -> data_write 8'h12; simultaneous inc/dec -> no write; a second pulse while pending -> a single write only.
REQ-041 Reset asserted at transaction cycle 100 -> next cycle shows reset values; sweep restarts at 8'h21 after release.
REQ-042 With RTC_SEQ_BCD_CHECK_EN, data_vga 8'h3A captured for hour -> hora = 8'h00 and bcd_err = 1.
